// File: rtl/code_stream_aligner_pkg.sv
// code_stream_aligner_pkg: constants, state encoding and helpers shared by the
// code stream aligner and the upstream literal/distance packer.
//   OUT_W        aligned output word width (fixed at 32)
//   BUF_W        bit-buffer width (2 * OUT_W)
//   LEN_W        width of the code-length field (legal values 0..32)
//   CNT_W        width of the buffered-bit counter (0..64)
//   MAX_CODE_LEN longest code the packer may present
package code_stream_aligner_pkg;

    localparam int unsigned OUT_W        = 32;
    localparam int unsigned BUF_W        = 64;
    localparam int unsigned LEN_W        = 6;
    localparam int unsigned CNT_W        = 7;
    localparam int unsigned MAX_CODE_LEN = 32;

    localparam logic [CNT_W-1:0] WORD_BITS = 7'(OUT_W);
    localparam logic [LEN_W-1:0] MAX_LEN   = 6'(MAX_CODE_LEN);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StTail,
        StDone
    } state_e;

    // Number of bytes needed to hold 'bits' bits (ceil(bits / 8)), for 1..32 bits.
    function automatic logic [2:0] bytes_for_bits(input logic [CNT_W-1:0] bits);
        return 3'((bits + 7'd7) >> 3);
    endfunction

endpackage

// File: rtl/code_stream_aligner_if.sv
// code_stream_aligner_if: code input, flush control and aligned word output of
// one Deflate lane aligner.
//   in_valid/in_ready/in_code/in_len  packed code handshake (LSB first on the wire)
//   flush_req/flush_done              end-of-block request and completion pulse
//   out_valid/out_ready/out_data      aligned 32-bit word handshake
//   out_bytes/out_last                valid bytes in the word, final word of block
//   stat_bits                         bits accepted in block (CODE_STREAM_STATS_EN only)
// master: the side feeding codes and draining words; slave: the aligner.
interface code_stream_aligner_if;
    import code_stream_aligner_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] in_code;
    logic [LEN_W-1:0] in_len;
    logic             flush_req;
    logic             flush_done;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_bytes;
    logic             out_last;
`ifdef CODE_STREAM_STATS_EN
    logic [31:0]      stat_bits;
`endif

    modport master (
        output in_valid, in_code, in_len, flush_req, out_ready,
`ifdef CODE_STREAM_STATS_EN
        input  stat_bits,
`endif
        input  in_ready, flush_done, out_valid, out_data, out_bytes, out_last
    );

    modport slave (
        input  in_valid, in_code, in_len, flush_req, out_ready,
`ifdef CODE_STREAM_STATS_EN
        output stat_bits,
`endif
        output in_ready, flush_done, out_valid, out_data, out_bytes, out_last
    );

endinterface

// File: rtl/code_stream_aligner_bit_inserter.sv
// code_stream_aligner_bit_inserter: combinational masked shift-OR of a code
// into the 64-bit bit buffer at a dynamic bit offset.
//   acc_in   current buffer contents (bits at/above offset must be zero)
//   code     packed code, LSB first; bits at/above len are discarded
//   len      number of valid code bits, 0..32 (already clamped)
//   offset   bit position where the first code bit lands
//   acc_out  buffer with the code merged in
module code_stream_aligner_bit_inserter
    import code_stream_aligner_pkg::*;
(
    input  logic [BUF_W-1:0] acc_in,
    input  logic [OUT_W-1:0] code,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] offset,
    output logic [BUF_W-1:0] acc_out
);

    logic [BUF_W-1:0] one;
    logic [BUF_W-1:0] mask;
    logic [BUF_W-1:0] code_ext;

    always_comb begin
        one      = {{(BUF_W-1){1'b0}}, 1'b1};
        // len = 0 yields an all-zero mask, so the insert degenerates to a no-op.
        mask     = (one << len) - one;
        code_ext = {{(BUF_W-OUT_W){1'b0}}, code} & mask;
        acc_out  = acc_in | (code_ext << offset);
    end

endmodule

// File: rtl/code_stream_aligner.sv
// code_stream_aligner: accumulates variable-length LSB-first codes into a
// 64-bit bit buffer and emits aligned 32-bit words. A flush drains the buffer,
// zero-pads the final partial word, tags it last with its byte count and then
// pulses flush_done.
//   clk    core clock
//   rst_n  asynchronous active-low reset; discards all buffered bits
//   bus    code_stream_aligner_if.slave (code in, flush, aligned words out)
// Optional: define CODE_STREAM_STATS_EN to add bus.stat_bits, a saturating
// count of code bits accepted in the current block.
module code_stream_aligner
    import code_stream_aligner_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    code_stream_aligner_if.slave bus
);

    state_e           state_q, state_d;
    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_en_q;

    logic             out_valid;
    logic             out_fire;
    logic             in_ready;
    logic             in_fire;
    logic [CNT_W-1:0] cnt_after_out;
    logic [LEN_W-1:0] len_clamped;
    logic [BUF_W-1:0] bits_shifted;
    logic [BUF_W-1:0] bits_inserted;

    // Output side: full words in RUN/DRAIN, the padded partial word in TAIL.
    always_comb begin
        out_valid = 1'b0;
        unique case (state_q)
            StRun, StDrain: out_valid = (cnt_q >= WORD_BITS);
            StTail:         out_valid = 1'b1;
            default:        out_valid = 1'b0;
        endcase
    end

    // Input side sees the buffer as it will be after this cycle's word leaves,
    // which lets a word go out and a code come in on the same cycle.
    always_comb begin
        out_fire      = out_valid && bus.out_ready;
        cnt_after_out = (out_fire && (state_q != StTail)) ? cnt_q - WORD_BITS : cnt_q;
        bits_shifted  = out_fire ? {{OUT_W{1'b0}}, bits_q[BUF_W-1:OUT_W]} : bits_q;
        in_ready      = ready_en_q && (state_q == StRun) && (cnt_after_out <= WORD_BITS);
        in_fire       = bus.in_valid && in_ready;
        len_clamped   = (bus.in_len > MAX_LEN) ? MAX_LEN : bus.in_len;
    end

    code_stream_aligner_bit_inserter u_bit_inserter (
        .acc_in  (bits_shifted),
        .code    (bus.in_code),
        .len     (len_clamped),
        .offset  (cnt_after_out),
        .acc_out (bits_inserted)
    );

    always_comb begin
        state_d = state_q;
        bits_d  = bits_shifted;
        cnt_d   = cnt_after_out;

        if (in_fire) begin
            bits_d = bits_inserted;
            cnt_d  = cnt_after_out + {1'b0, len_clamped};
        end

        unique case (state_q)
            StRun: begin
                // A code accepted alongside flush_req still belongs to this block.
                if (bus.flush_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cnt_q < WORD_BITS) begin
                    state_d = (cnt_q != '0) ? StTail : StDone;
                end
            end
            StTail: begin
                if (out_fire) begin
                    state_d = StDone;
                    bits_d  = '0;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            bits_q     <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

    // Buffer bits at/above cnt are always zero, so the tail word is already padded.
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = bits_q[OUT_W-1:0];
    assign bus.out_bytes  = (state_q == StTail) ? bytes_for_bits(cnt_q) : 3'd4;
    assign bus.out_last   = (state_q == StTail);
    assign bus.flush_done = (state_q == StDone);

`ifdef CODE_STREAM_STATS_EN
    logic [31:0] stat_q, stat_d;
    logic [32:0] stat_sum;

    always_comb begin
        stat_d   = stat_q;
        stat_sum = {1'b0, stat_q} + {27'b0, len_clamped};
        if (state_q == StDone) begin
            stat_d = '0;
        end else if (in_fire) begin
            stat_d = stat_sum[32] ? '1 : stat_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign bus.stat_bits = stat_q;
`endif

    a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.in_valid && in_ready) |-> (bus.in_len <= MAX_LEN));

    a_flush_in_run: assert property (@(posedge clk) disable iff (!rst_n)
        bus.flush_req |-> (state_q == StRun));

endmodule

// File: tb/tb_code_stream_aligner.sv
module tb_code_stream_aligner;
    import code_stream_aligner_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    code_stream_aligner_if bus ();

    code_stream_aligner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    bit rand_ready = 1'b0;

    // Scoreboard: bits accepted in the current block, and words observed.
    bit          exp_bits[$];
    logic [31:0] got_data[$];
    logic [2:0]  got_bytes[$];
    bit          got_last[$];
    logic [31:0] exp_data[$];
    logic [2:0]  exp_bytes[$];
    bit          exp_last[$];

    bit          in_fired;
    bit          ready_s;
    bit          ov_s;
    logic [31:0] od_s;
    int          last_out_cyc = -1;
    int          done_cyc     = -1;
    int          done_seen    = 0;

    // One clock: entered just after a falling edge, returns at the next one.
    task automatic tick();
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        in_fired = 1'b0;
        ready_s  = bus.in_ready;
        ov_s     = bus.out_valid;
        od_s     = bus.out_data;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            for (int i = 0; i < int'(bus.in_len); i++) exp_bits.push_back(bus.in_code[i]);
            in_fired = 1'b1;
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_bytes.push_back(bus.out_bytes);
            got_last.push_back(bus.out_last);
            last_out_cyc = cyc;
        end
        if (rst_n && bus.flush_done) begin
            done_seen++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_code(input logic [31:0] code, input int len);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        bus.in_len   = 6'(len);
        do begin
            tick();
            n++;
        end while (!in_fired && n < 200);
        bus.in_valid = 1'b0;
        bus.in_code  = $urandom;
        if (!in_fired) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_code: code %h len %0d not accepted within 200 cycles", code, len);
        end
    endtask

    task automatic do_flush(output int latency, output int ready_hi);
        int start = cyc;
        int d0    = done_seen;
        int n     = 0;
        ready_hi = 0;
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        while (done_seen == d0 && n < 400) begin
            tick();
            if (ready_s) ready_hi++;
            n++;
        end
        latency = done_cyc - start;
        if (done_seen == d0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL flush_done: not seen within 400 cycles");
            latency = 9999;
        end
    endtask

    // Reference: chop the block's bitstream into 32-bit words; a leftover
    // partial word is zero-padded, tagged last, with ceil(bits/8) bytes.
    task automatic build_model();
        exp_data.delete();
        exp_bytes.delete();
        exp_last.delete();
        while (exp_bits.size() > 0) begin
            logic [31:0] w = '0;
            int          n = (exp_bits.size() >= 32) ? 32 : exp_bits.size();
            for (int i = 0; i < n; i++) w[i] = exp_bits.pop_front();
            exp_data.push_back(w);
            exp_bytes.push_back(3'((n + 7) / 8));
            exp_last.push_back(n < 32);
        end
    endtask

    task automatic clear_all();
        exp_bits.delete();
        got_data.delete();
        got_bytes.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        end
        tests_run++;
        if (bus.out_bytes !== 3'd4 || bus.out_last !== 1'b0 || bus.flush_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_misc: bytes %0d last %b done %b want 4 0 0",
                     bus.out_bytes, bus.out_last, bus.flush_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tick();
        tick();
        tests_run++;
        if (ready_s !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready_after: got %b want 1", ready_s);
        end
        clear_all();
    endtask

    task automatic test_bytes();
        logic [31:0] want [2] = '{32'h44332211, 32'h88776655};
        int start;
        clear_all();
        bus.out_ready = 1'b1;
        start = cyc;
        for (int i = 1; i <= 8; i++) send_code(32'(i * 8'h11), 8);
        tests_run++;
        if (cyc - start !== 8) begin
            tests_failed++; $display("FAIL bytes_no_stall: took %0d cycles want 8", cyc - start);
        end
        tick();
        tick();
        tests_run++;
        if (got_data.size() !== 2) begin
            tests_failed++; $display("FAIL bytes_count: got %0d words want 2", got_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (got_data[i] !== want[i] || got_bytes[i] !== 3'd4 || got_last[i] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL bytes_word%0d: got %h/%0d/%b want %h/4/0",
                             i, got_data[i], got_bytes[i], got_last[i], want[i]);
                end
            end
        end
        clear_all();
    endtask

    task automatic test_straddle();
        clear_all();
        bus.out_ready = 1'b1;
        send_code(32'h1FF, 9);
        send_code(32'h000001, 23);
        tests_run++;
        if (got_data.size() !== 0) begin
            tests_failed++; $display("FAIL straddle_early: got %0d words want 0", got_data.size());
        end
        tick();
        tests_run++;
        if (got_data.size() !== 1 || got_data[0] !== 32'h000003FF) begin
            tests_failed++;
            $display("FAIL straddle_word: got %0d words first %h want 1 x 000003ff",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'hx);
        end
        tick();
        clear_all();
    endtask

    task automatic test_tail_flush();
        int lat, rh;
        clear_all();
        bus.out_ready = 1'b1;
        send_code(32'hFFFABCDE, 20);
        do_flush(lat, rh);
        tests_run++;
        if (got_data.size() !== 1 || got_data[0] !== 32'h000ABCDE || got_bytes[0] !== 3'd3
            || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL tail_word: got %0d words first %h/%0d/%b want 000abcde/3/1",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx,
                     got_bytes.size() > 0 ? got_bytes[0] : 3'hx,
                     got_last.size() > 0 ? got_last[0] : 1'bx);
        end
        tests_run++;
        if (done_cyc !== last_out_cyc + 1) begin
            tests_failed++;
            $display("FAIL tail_done_timing: done at %0d last word at %0d want +1",
                     done_cyc, last_out_cyc);
        end
        tests_run++;
        if (rh !== 0) begin
            tests_failed++; $display("FAIL tail_in_ready: high %0d cycles during flush want 0", rh);
        end
        clear_all();
    endtask

    task automatic test_backpressure();
        logic [31:0] c0 = $urandom;
        int stall_bad = 0, data_bad = 0, n = 0, lat, rh;
        clear_all();
        bus.out_ready = 1'b0;
        send_code(c0, 32);
        send_code($urandom, 32);
        bus.in_valid = 1'b1;
        bus.in_code  = $urandom;
        bus.in_len   = 6'd32;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready_s) stall_bad++;
            if (!ov_s || od_s !== c0) data_bad++;
        end
        tests_run++;
        if (stall_bad !== 0) begin
            tests_failed++; $display("FAIL bp_in_ready: high %0d of 6 stalled cycles want 0", stall_bad);
        end
        tests_run++;
        if (data_bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d cycles out_data/valid not %h/1 (last %h)", data_bad, c0, od_s);
        end
        bus.out_ready = 1'b1;
        do begin
            tick();
            n++;
        end while (!in_fired && n < 50);
        bus.in_valid = 1'b0;
        tests_run++;
        if (!in_fired) begin
            tests_failed++; $display("FAIL bp_release: code not accepted after release");
        end
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_code($urandom, $urandom_range(0, 32));
        do_flush(lat, rh);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        build_model();
        tests_run++;
        if (got_data.size() !== exp_data.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d words want %0d", got_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                tests_run++;
                if (got_data[i] !== exp_data[i] || got_bytes[i] !== exp_bytes[i]
                    || got_last[i] !== exp_last[i]) begin
                    tests_failed++;
                    $display("FAIL bp_word%0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[i],
                             got_bytes[i], got_last[i], exp_data[i], exp_bytes[i], exp_last[i]);
                end
            end
        end
        clear_all();
    endtask

    task automatic test_empty_flush();
        int lat, rh;
        clear_all();
        bus.out_ready = 1'b1;
        do_flush(lat, rh);
        tests_run++;
        if (lat > 2) begin
            tests_failed++; $display("FAIL empty_latency: flush_done after %0d cycles want <=2", lat);
        end
        tests_run++;
        if (got_data.size() !== 0) begin
            tests_failed++; $display("FAIL empty_words: got %0d words want 0", got_data.size());
        end
        clear_all();
    endtask

    task automatic test_exact64();
        int lat, rh;
        clear_all();
        bus.out_ready = 1'b1;
        send_code($urandom, 32);
        send_code($urandom, 32);
        do_flush(lat, rh);
        build_model();
        tests_run++;
        if (got_data.size() !== exp_data.size() || got_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL exact64_count: got %0d words want 2", got_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (got_data[i] !== exp_data[i] || got_bytes[i] !== 3'd4 || got_last[i] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL exact64_word%0d: got %h/%0d/%b want %h/4/0", i, got_data[i],
                             got_bytes[i], got_last[i], exp_data[i]);
                end
            end
        end
        clear_all();
    endtask

    task automatic test_random();
        int lat, rh;
        for (int blk = 0; blk < 6; blk++) begin
            clear_all();
            rand_ready = 1'b1;
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
                send_code($urandom, $urandom_range(0, 32));
            end
            do_flush(lat, rh);
            rand_ready = 1'b0;
            bus.out_ready = 1'b1;
            build_model();
            tests_run++;
            if (got_data.size() !== exp_data.size()) begin
                tests_failed++;
                $display("FAIL rand%0d_count: got %0d words want %0d", blk, got_data.size(),
                         exp_data.size());
            end else begin
                for (int i = 0; i < exp_data.size(); i++) begin
                    tests_run++;
                    if (got_data[i] !== exp_data[i] || got_bytes[i] !== exp_bytes[i]
                        || got_last[i] !== exp_last[i]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_word%0d: got %h/%0d/%b want %h/%0d/%b", blk, i,
                                 got_data[i], got_bytes[i], got_last[i], exp_data[i],
                                 exp_bytes[i], exp_last[i]);
                    end
                end
            end
        end
        clear_all();
    endtask

    task automatic test_mid_reset();
        int lat, rh;
        clear_all();
        bus.out_ready = 1'b0;
        send_code($urandom, 32);
        send_code($urandom, 8);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_bytes !== 3'd4
            || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0 || bus.flush_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: valid %b data %h bytes %0d last %b ready %b done %b",
                     bus.out_valid, bus.out_data, bus.out_bytes, bus.out_last, bus.in_ready,
                     bus.flush_done);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        clear_all();
        bus.out_ready = 1'b1;
        send_code(32'hFFFFFF5A, 8);
        do_flush(lat, rh);
        tests_run++;
        if (got_data.size() !== 1 || got_data[0] !== 32'h0000005A || got_bytes[0] !== 3'd1
            || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_fresh: got %0d words first %h/%0d want 0000005a/1",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 32'hx,
                     got_bytes.size() > 0 ? got_bytes[0] : 3'hx);
        end
        clear_all();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_len    = '0;
        bus.flush_req = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_bytes();
        test_straddle();
        test_tail_flush();
        test_backpressure();
        test_empty_flush();
        test_exact64();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
